// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared definitions for the unified memory controller: bus
//               widths and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/unified_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_ctrl_if
// Description : Bus bundle for the unified memory controller. Carries the CPU
//               request/response signals and the backing-memory strobe bus.
//               master : controller view (serves the CPU, drives the memory)
//               slave  : environment view (CPU + backing memory)
// Signals     : i_fetch, i_addr, re, we, d_addr, wrt_data  (CPU requests)
//               instr, rd_data, ready                      (CPU responses)
//               mem_addr, mem_wdata, mem_re, mem_we        (memory command)
//               mem_rdata, mem_valid                       (memory response)
// Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              i_fetch;
    logic [ADDR_W-1:0] i_addr;
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] wrt_data;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] rd_data;
    logic              ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport master (
        input  i_fetch, i_addr, re, we, d_addr, wrt_data,
        output instr, rd_data, ready,
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_valid
    );

    modport slave (
        output i_fetch, i_addr, re, we, d_addr, wrt_data,
        input  instr, rd_data, ready,
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_valid
    );

endinterface
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : Single-entry instruction fetch buffer (tag, valid, data).
//               Reports a hit for lookup_addr; a matching write invalidates the
//               entry, and the hit output already reflects that invalidation
//               in the same cycle.
// Ports       : clk, rst_n               - clock, async active-low reset
//               lookup_addr              - address compared against the tag
//               load, load_addr/load_data - fill the entry
//               inval, inval_addr        - completed write for coherence
//               hit, data                - lookup result and stored word
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              inval,
    input  logic [ADDR_W-1:0] inval_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data_q;
    logic              inval_match;

    assign inval_match = inval & valid & (inval_addr == tag);

    // Masking with inval_match lets the controller decide on a refetch in the
    // same cycle the write to the buffered address completes.
    assign hit  = valid & ~inval_match & (tag == lookup_addr);
    assign data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag    <= '0;
            data_q <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            tag    <= load_addr;
            data_q <= load_data;
        end else if (inval_match) begin
            valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_ctrl
// Description : Arbitrates CPU data accesses and instruction fetches onto one
//               backing memory. Data access goes first, then an instruction
//               fetch on a buffer miss, then a one-cycle DONE with ready high.
//               Pure buffer hits complete in IDLE with no added cycles.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - CPU request/response and backing-memory bus
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    unified_mem_ctrl_if.master bus
);

    state_t            state;
    state_t            state_nxt;

    logic              hit;
    logic [DATA_W-1:0] buf_data;
    logic              data_req;
    logic              fetch_miss;
    logic              wr_done;
    logic              rd_done;
    logic              fill;

    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] rd_q;

    logic              ready_c;
    logic              mem_re_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    assign data_req   = bus.re | bus.we;
    assign fetch_miss = bus.i_fetch & ~hit;
    // Write wins when re and we are both high, so a read completes only with we low.
    assign wr_done    = (state == D_ACC) & bus.we & bus.mem_valid;
    assign rd_done    = (state == D_ACC) & ~bus.we & bus.mem_valid;
    assign fill       = (state == I_ACC) & bus.mem_valid;

    fetch_buf u_fetch_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (bus.i_addr),
        .load        (fill),
        .load_addr   (bus.i_addr),
        .load_data   (bus.mem_rdata),
        .inval       (wr_done),
        .inval_addr  (bus.d_addr),
        .hit         (hit),
        .data        (buf_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes and address are decoded straight from state, so reset drops
    // them immediately and a late mem_valid finds the FSM in IDLE.
    always_comb begin
        state_nxt   = state;
        ready_c     = 1'b0;
        mem_re_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        case (state)
            IDLE: begin
                ready_c = ~(data_req | fetch_miss);
                if (data_req) begin
                    state_nxt = D_ACC;
                end else if (fetch_miss) begin
                    state_nxt = I_ACC;
                end
            end
            D_ACC: begin
                mem_addr_c = bus.d_addr;
                if (bus.we) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = bus.wrt_data;
                end else begin
                    mem_re_c    = 1'b1;
                end
                if (bus.mem_valid) begin
                    state_nxt = fetch_miss ? I_ACC : DONE;
                end
            end
            I_ACC: begin
                mem_addr_c = bus.i_addr;
                mem_re_c   = 1'b1;
                if (bus.mem_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready_c   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            rd_q    <= '0;
        end else begin
            if (rd_done) begin
                rd_q <= bus.mem_rdata;
            end
            if (fill) begin
                instr_q <= bus.mem_rdata;
            end else if ((state == IDLE) && bus.i_fetch && hit) begin
                // Keep the held value in step with hits served from the buffer.
                instr_q <= buf_data;
            end
        end
    end

    assign bus.instr     = (bus.i_fetch & hit) ? buf_data : instr_q;
    assign bus.rd_data   = rd_q;
    assign bus.ready     = ready_c;
    assign bus.mem_re    = mem_re_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

endmodule
`default_nettype wire

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port i_fetch, input, 1, CPU instruction-fetch request for i_addr.
REQ-004 SHALL have port i_addr, input, 16, instruction word address.
REQ-005 SHALL have port re, input, 1, CPU data-read request.
REQ-006 SHALL have port we, input, 1, CPU data-write request.
REQ-007 SHALL have port d_addr, input, 16, data word address.
REQ-008 SHALL have port wrt_data, input, 16, data to write.
REQ-009 SHALL have port instr, output, 16, fetched instruction, held until the next fetch completes.
REQ-010 SHALL have port rd_data, output, 16, read data, held until the next read completes.
REQ-011 SHALL have port ready, output, 1, high when all pending CPU requests are complete and the pipeline may advance.
REQ-012 SHALL have port mem_addr, output, 16, backing-memory word address.
REQ-013 SHALL have port mem_wdata, output, 16, backing-memory write data.
REQ-014 SHALL have port mem_re, output, 1, backing-memory read strobe, held until mem_valid.
REQ-015 SHALL have port mem_we, output, 1, backing-memory write strobe, held until mem_valid.
REQ-016 SHALL have port mem_rdata, input, 16, backing-memory read data, valid with mem_valid.
REQ-017 SHALL have port mem_valid, input, 1, backing-memory completion; a single-cycle pulse of 1 or more cycles after the strobe.

Function
REQ-018 SHALL implement the FSM states IDLE, D_ACC, I_ACC and DONE.
REQ-019 IDLE SHALL drive ready = ~(re|we|(i_fetch & ~hit)) combinationally, where "hit" means fetch-buffer valid and tag == i_addr.
REQ-020 From IDLE, the FSM SHALL go to D_ACC if re|we, else to I_ACC if i_fetch & ~hit, else stay in IDLE.
REQ-021 D_ACC SHALL drive mem_addr=d_addr and assert mem_we if we, otherwise mem_re.
REQ-022 If re and we are both high, the write SHALL win and rd_data SHALL be unchanged.
REQ-023 On mem_valid in D_ACC, a read SHALL capture mem_rdata into rd_data.
REQ-024 On mem_valid in D_ACC, the FSM SHALL go to I_ACC if i_fetch & ~hit (hit is evaluated after the write invalidation of REQ-029), else to DONE.
REQ-025 I_ACC SHALL drive mem_addr=i_addr and mem_re=1.
REQ-026 On mem_valid in I_ACC, the block SHALL load instr and the buffer data from mem_rdata, set tag=i_addr and valid=1, and go to DONE.
REQ-027 DONE SHALL drive ready=1 for exactly one cycle and then go to IDLE.
REQ-028 On a hit, instr SHALL be driven from the buffer data; an access that is a pure hit SHALL complete in IDLE with zero added cycles.
REQ-029 A completed write with d_addr == tag SHALL clear valid in the same cycle (self-modifying-code coherence).
REQ-030 The strobes SHALL be mutually exclusive and asserted only in D_ACC or I_ACC; the address and wdata SHALL be stable while a strobe is high.
REQ-031 The block SHALL ignore mem_valid in IDLE and DONE.
REQ-032 CPU inputs SHALL be sampled while ready=0; the CPU holds them stable per protocol, so the block needs no internal latching.
REQ-033 Worst-case latency SHALL be 2 backing accesses + 1 cycle (DONE).
REQ-034 Address arithmetic SHALL be none; addresses SHALL pass through at 16 bits, word-addressed.

Reset
REQ-035 Asserting rst_n low at any time, including mid-access, SHALL force state=IDLE, mem_re=mem_we=0, mem_addr=mem_wdata=0, instr=rd_data=0, valid=0 and tag=0.
REQ-036 ready SHALL follow REQ-019 after reset, so it is high with no requests.
REQ-037 A mem_valid that arrives after reset for an aborted access SHALL be ignored.

Structure
REQ-038 The shared package mem_ctrl_pkg SHALL hold the state typedef (IDLE, D_ACC, I_ACC, DONE) and the width constants ADDR_W=16 and DATA_W=16.
REQ-039 The single-entry fetch buffer (tag, valid, data, hit compare, invalidate) SHALL be the sub-module fetch_buf; the FSM and muxing SHALL stay in unified_mem_ctrl.

Verification
REQ-040 Fetch miss: i_fetch=1, i_addr=0x0010, mem_valid 3 cycles after mem_re with mem_rdata=0xB123 -> instr=0xB123, ready pulses once 1 cycle after mem_valid.
REQ-041 Repeat fetch of 0x0010 with no data access -> no mem_re, ready=1 the same cycle, instr=0xB123.
REQ-042 re=1, d_addr=0x0200, plus fetch miss at 0x0011 -> a D_ACC read returns 0x5555 and then an I_ACC returns 0x1234, in that order; rd_data=0x5555, instr=0x1234, single ready pulse.
REQ-043 Write we=1, d_addr=0x0010, wrt_data=0xAAAA after REQ-041 -> mem_we with mem_wdata=0xAAAA, buffer invalidated; the next fetch of 0x0010 issues mem_re.
REQ-044 re=we=1 -> only mem_we is issued and rd_data is unchanged.
REQ-045 rst_n low while in I_ACC with mem_re high -> mem_re=0 and state=IDLE immediately; a late mem_valid causes no change to instr.
